// File: rtl/pwm_peripheral.sv
// 16-channel PWM output stage fed by the SPI register file; one shared prescaled 8-bit counter.
// Optional macro PWM_SYNC_UPDATE_EN latches the duty value only at PWM period boundaries.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out
);

  localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [15:0]      out_q, out_d;
  logic [15:0]      en_out, en_pwm;
  logic [7:0]       duty_eff;
  logic             tick;
  logic             pwm_raw;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

`ifdef PWM_SYNC_UPDATE_EN
  logic [7:0] duty_shadow_q, duty_shadow_d;

  // Duty is captured on the last cycle of a period so the next period starts with it.
  always_comb begin
    duty_shadow_d = duty_shadow_q;
    if (tick && (pwm_cnt_q == 8'hFF)) begin
      duty_shadow_d = pwm_duty_cycle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow_q <= '0;
    end else begin
      duty_shadow_q <= duty_shadow_d;
    end
  end

  assign duty_eff = duty_shadow_q;
`else
  assign duty_eff = pwm_duty_cycle;
`endif

  always_comb begin
    tick      = (pre_cnt_q == PRE_MAX);
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
  end

  // 0xFF is forced to 100% since the compare alone would leave one low step per period.
  always_comb begin
    pwm_raw = (duty_eff == 8'hFF) || (pwm_cnt_q < duty_eff);
    out_d   = en_out & (~en_pwm | {16{pwm_raw}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
      out_q     <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      out_q     <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: cycle-level reference model plus period/high-time measurements.
module tb_pwm_peripheral;

  localparam int unsigned CDIV = 13;
  localparam int unsigned PER  = 256 * CDIV;
`ifdef PWM_SYNC_UPDATE_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] en_o = '0;
  logic [15:0] en_p = '0;
  logic [7:0]  duty = '0;
  logic [15:0] out;

  int checks = 0;
  int errors = 0;

  pwm_peripheral #(.CLK_DIV(CDIV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_o[7:0]),
    .en_reg_out_15_8 (en_o[15:8]),
    .en_reg_pwm_7_0  (en_p[7:0]),
    .en_reg_pwm_15_8 (en_p[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out)
  );

  always #5 clk = ~clk;

  // Reference model: counter value derived from the number of edges since reset release.
  int unsigned k;
  logic [7:0]  m_shadow;
  logic [15:0] exp_q;

  function automatic logic [15:0] model_out(input int unsigned kk, input logic [7:0] deff,
                                            input logic [15:0] eo, input logic [15:0] ep);
    int unsigned pc;
    logic        raw;
    logic [15:0] r;
    pc  = (kk / CDIV) % 256;
    raw = (deff == 8'hFF) || (pc < 32'(deff));
    for (int i = 0; i < 16; i++) r[i] = eo[i] ? (ep[i] ? raw : 1'b1) : 1'b0;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= 0;
      m_shadow <= '0;
      exp_q    <= '0;
    end else begin
      exp_q <= model_out(k, SYNC ? m_shadow : duty, en_o, en_p);
      if (k % PER == PER - 1) m_shadow <= duty;
      k <= k + 1;
    end
  end

  task automatic measure(input int b, output int hi, output int per, output bit ok);
    int n;
    ok = 1'b1; hi = 0; per = 0; n = 0;
    while (out[b] === 1'b1 && n < PER) begin @(negedge clk); n++; end
    n = 0;
    while (out[b] !== 1'b1 && n < 2 * PER) begin @(negedge clk); n++; end
    if (n >= 2 * PER) ok = 1'b0;
    while (out[b] === 1'b1 && hi <= PER) begin @(negedge clk); hi++; end
    per = hi;
    while (out[b] !== 1'b1 && per <= PER) begin @(negedge clk); per++; end
    if (hi > PER || per > PER) ok = 1'b0;
  endtask

  task automatic test_reset();
    int hi;
    rst_n = 1'b0; en_o = '1; en_p = '1; duty = 8'hFF;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (out !== 16'h0000) begin errors++; $display("FAIL reset_hold: out=%h exp=0000", out); end
    end
    duty = 8'h01;
    rst_n = 1'b1;
    hi = 0;
    repeat (2 * CDIV + 2) begin
      @(negedge clk);
      if (out[0]) hi++;
      checks++;
      if (out !== exp_q) begin errors++; $display("FAIL model_reset: out=%h exp=%h t=%0t", out, exp_q, $time); end
    end
    checks++;
    if (hi != (SYNC ? 0 : int'(CDIV)))
      begin errors++; $display("FAIL first_step: high=%0d exp=%0d", hi, SYNC ? 0 : CDIV); end
  endtask

  task automatic test_static();
    duty = 8'($urandom); en_o = 16'h00FF; en_p = 16'h0000;
    @(negedge clk);
    checks++;
    if (out !== 16'h00FF) begin errors++; $display("FAIL static_high: out=%h exp=00FF", out); end
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (out !== exp_q) begin errors++; $display("FAIL model_static: out=%h exp=%h", out, exp_q); end
    end
    en_o = 16'h0000; en_p = 16'($urandom); duty = 8'($urandom);
    @(negedge clk);
    checks++;
    if (out !== 16'h0000) begin errors++; $display("FAIL disabled: out=%h exp=0000", out); end
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (out !== exp_q) begin errors++; $display("FAIL model_disabled: out=%h exp=%h", out, exp_q); end
    end
  endtask

  task automatic test_pwm50();
    int hi, per, b;
    bit ok;
    en_o = '1; en_p = '1; duty = 8'h80;
    repeat (PER) begin
      @(negedge clk);
      checks++;
      if (out !== exp_q) begin errors++; $display("FAIL model_pwm50: out=%h exp=%h", out, exp_q); end
    end
    b = int'($urandom_range(15, 0));
    measure(b, hi, per, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pwm50_timeout: bit=%0d", b); end
    checks++;
    if (hi != 1664 || per != 3328)
      begin errors++; $display("FAIL pwm50_shape: bit=%0d high=%0d period=%0d exp 1664/3328", b, hi, per); end
  endtask

  task automatic test_extremes();
    int cnt, hi, per;
    bit ok;
    en_o = '1; en_p = '1; duty = 8'h00;
    repeat (PER) begin
      @(negedge clk);
      checks++;
      if (out !== exp_q) begin errors++; $display("FAIL model_duty00: out=%h exp=%h", out, exp_q); end
    end
    cnt = 0;
    repeat (PER) begin @(negedge clk); if (out !== 16'h0000) cnt++; end
    checks++;
    if (cnt != 0) begin errors++; $display("FAIL duty00: high_cycles=%0d exp=0", cnt); end
    duty = 8'hFF;
    repeat (PER) begin
      @(negedge clk);
      checks++;
      if (out !== exp_q) begin errors++; $display("FAIL model_dutyFF: out=%h exp=%h", out, exp_q); end
    end
    cnt = 0;
    repeat (PER) begin @(negedge clk); if (out !== 16'hFFFF) cnt++; end
    checks++;
    if (cnt != 0) begin errors++; $display("FAIL dutyFF: low_cycles=%0d exp=0", cnt); end
    duty = 8'h01;
    repeat (PER) @(negedge clk);
    measure(3, hi, per, ok);
    checks++;
    if (!ok || hi != int'(CDIV) || per != int'(PER))
      begin errors++; $display("FAIL duty01: high=%0d period=%0d ok=%0d exp %0d/%0d", hi, per, ok, CDIV, PER); end
  endtask

  task automatic test_mixed();
    int hi, per, b;
    bit ok;
    en_o = 16'hF0F0; en_p = 16'hFF00; duty = 8'h40;
    repeat (PER) begin
      @(negedge clk);
      checks++;
      if (out !== exp_q) begin errors++; $display("FAIL model_mixed: out=%h exp=%h", out, exp_q); end
    end
    b = 12 + int'($urandom_range(3, 0));
    measure(b, hi, per, ok);
    checks++;
    if (!ok || hi != 832 || per != 3328)
      begin errors++; $display("FAIL mixed_pwm: bit=%0d high=%0d period=%0d exp 832/3328", b, hi, per); end
    repeat (50) begin
      @(negedge clk);
      checks++;
      if ((out & 16'h0FFF) !== 16'h00F0) begin errors++; $display("FAIL mixed_static: out=%h exp low12=0F0", out); end
    end
  endtask

  task automatic test_sync();
    int n, hi, hi2, per;
    bit ok;
    en_o = '1; en_p = '1; duty = 8'h40;
    repeat (PER) @(negedge clk);
    n = 0;
    while (out[0] !== 1'b0 && n < int'(PER)) begin @(negedge clk); n++; end
    n = 0;
    while (out[0] !== 1'b1 && n < 2 * int'(PER)) begin @(negedge clk); n++; end
    checks++;
    if (n >= 2 * int'(PER)) begin errors++; $display("FAIL sync_rise_timeout: waited=%0d", n); end
    hi = 0;
    while (out[0] === 1'b1 && hi <= int'(PER)) begin
      if (hi == 32 * int'(CDIV)) duty = 8'hC0;
      @(negedge clk);
      hi++;
      checks++;
      if (out !== exp_q) begin errors++; $display("FAIL model_sync: out=%h exp=%h", out, exp_q); end
    end
    checks++;
    if (hi != (SYNC ? 832 : 2496))
      begin errors++; $display("FAIL sync_current: high=%0d exp=%0d", hi, SYNC ? 832 : 2496); end
    measure(0, hi2, per, ok);
    checks++;
    if (!ok || hi2 != 2496 || per != 3328)
      begin errors++; $display("FAIL sync_next: high=%0d period=%0d exp 2496/3328", hi2, per); end
  endtask

  task automatic test_reset_mid();
    int hi;
    en_o = '1; en_p = '1; duty = 8'hFF;
    repeat (2 * CDIV + 7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000) begin errors++; $display("FAIL reset_async: out=%h exp=0000", out); end
    duty = 8'h01;
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    repeat (PER + 3 * CDIV) begin
      @(negedge clk);
      if (out[5] && k <= PER) hi++;
      checks++;
      if (out !== exp_q) begin errors++; $display("FAIL model_reset_mid: out=%h exp=%h", out, exp_q); end
    end
    checks++;
    if (hi != (SYNC ? 0 : int'(CDIV)))
      begin errors++; $display("FAIL restart_phase: high=%0d exp=%0d", hi, SYNC ? 0 : CDIV); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      en_o = 16'($urandom); en_p = 16'($urandom); duty = 8'($urandom);
      repeat ($urandom_range(600, 50)) begin
        @(negedge clk);
        checks++;
        if (out !== exp_q) begin errors++; $display("FAIL model_random: out=%h exp=%h", out, exp_q); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_pwm50();
    test_extremes();
    test_mixed();
    test_sync();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Consumes the five configuration registers written by the SPI register block and drives 16 output pins. Each pin is forced low, driven static high, or driven with a shared PWM waveform. One 8-bit free-running PWM counter, advanced by a clock prescaler, is shared by all channels. The block sits directly downstream of the SPI register file and its outputs go straight to the pad outputs.

## Interface

Parameters:
- `CLK_DIV`, default 13: `clk` cycles per PWM counter step; legal range ≥1. At 10 MHz this gives ≈3 kHz PWM (256×13 cycles per period).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `en_reg_out_7_0`  in  8  output enable, channels 7..0.
- `en_reg_out_15_8`  in  8  output enable, channels 15..8.
- `en_reg_pwm_7_0`  in  8  PWM mode select, channels 7..0.
- `en_reg_pwm_15_8`  in  8  PWM mode select, channels 15..8.
- `pwm_duty_cycle`  in  8  shared duty value, 0x00–0xFF.
- `out`  out  16  registered channel outputs; bit i is channel i.

## Operation

Internal combine:
- `en_out[15:0] = {en_reg_out_15_8, en_reg_out_7_0}`.
- `en_pwm[15:0] = {en_reg_pwm_15_8, en_reg_pwm_7_0}`.

Prescaler `pre_cnt`:
- Width `$clog2(CLK_DIV)`, minimum 1 bit.
- Counts 0..CLK_DIV-1 and wraps.
- `tick` asserts combinationally when `pre_cnt == CLK_DIV-1`.
- With CLK_DIV=1, `tick` is constant 1.

PWM counter `pwm_cnt`:
- 8 bits; increments on `tick`; wraps 0xFF→0x00 with no idle state.

Effective duty `duty_eff`:
- Equals `pwm_duty_cycle`, or the shadow register (see Configuration).

PWM signal `pwm_raw`:
- `duty_eff == 0xFF` → 1 (100%, special case).
- Otherwise → `pwm_cnt < duty_eff` (unsigned 8-bit compare).
- 0x00 → constant 0.

Per-channel output i:
- `en_out[i]==0` → 0.
- Else `en_pwm[i]==0` → 1.
- Else → `pwm_raw`.

The enable and PWM-select registers take effect on the next `out` update, not at period boundaries. No other state.

## Timing

Reset values:
- `out` = 0x0000.
- `pre_cnt` = 0, `pwm_cnt` = 0, duty shadow = 0x00.

Period and high time:
- Period = 256×CLK_DIV cycles.
- High time = `duty_eff`×CLK_DIV cycles for duty < 0xFF.

Latency and phase:
- `out` is registered; any input or counter change is visible at `out` exactly one `clk` edge later.
- After reset release, `pwm_cnt` first increments on the CLK_DIV-th rising edge.
- Rising edge of a PWM channel occurs one cycle after `pwm_cnt` becomes 0x00 (duty ≠ 0).

Reset mid-period:
- All state clears immediately, asynchronously.
- The period restarts from `pwm_cnt` = 0 after release.

Duty changes:
- Without the macro, a change mid-period acts on the next compare, so one truncated or extended pulse is legal.
- With the macro, no partial pulses are produced.

## Configuration

Macro `PWM_SYNC_UPDATE_EN` (synchronised duty update):
- **Defined:** shadow register `duty_shadow` loads `pwm_duty_cycle` on the cycle where `tick && pwm_cnt == 0xFF`, and `duty_eff = duty_shadow`.
  - A new duty takes effect from the first cycle of the next period (`pwm_cnt` = 0x00).
  - After reset, PWM channels stay low for the whole first period.
- **Undefined:** no shadow register; `duty_eff = pwm_duty_cycle` directly.

## Test plan

1. **Reset:** hold `rst_n`=0 with all inputs 0xFF → `out`=0x0000; release → `pre_cnt`/`pwm_cnt` start at 0.
2. **Static high / disabled:**
   - en_out=0x00FF, en_pwm=0x0000 → `out`=0x00FF one cycle later.
   - en_out=0x0000 with any duty → `out`=0x0000.
3. **PWM 50%:** CLK_DIV=13, en_out=0xFFFF, en_pwm=0xFFFF, duty=0x80 (macro undefined) → every bit shows period 3328 cycles and high time 1664 cycles.
4. **Duty extremes:**
   - duty=0x00 → PWM bits never high over 2 periods.
   - duty=0xFF → PWM bits constantly high.
   - duty=0x01 → high exactly 13 cycles per period.
5. **Mixed channels:** en_out=0xF0F0, en_pwm=0xFF00, duty=0x40 → bits 15..12 PWM at 25%, bits 7..4 constant 1, all others 0.
6. **Synchronised update:** with `PWM_SYNC_UPDATE_EN` defined, change duty 0x40→0xC0 at `pwm_cnt`=0x20 → current period keeps 25% high time; the next period starts at 75%. Reset asserted mid-period → `out`=0 immediately.
